// File: rtl/fetch_sequencer_if.sv
// Handshake and control bundle between the fetch sequencer and the register file / execute controller.
// The master modport is the sequencer's side and the slave modport is the datapath side.
interface fetch_sequencer_if #(
  parameter int WORD_W = 16,
  parameter int SEL_W  = 3
);
  logic              start;
  logic              halt;
  logic              exec_done;
  logic [WORD_W-1:0] ir_data;
  logic              pc_increment;
  logic              ar_write;
  logic              ir_write;
  logic              mem_read;
  logic [SEL_W-1:0]  bus_select;
  logic [7:0]        opcode_d;
  logic              i_flag;
  logic              exec_start;
  logic [3:0]        t_count;

  modport master (
    input  start, halt, exec_done, ir_data,
    output pc_increment, ar_write, ir_write, mem_read, bus_select,
           opcode_d, i_flag, exec_start, t_count
  );

  modport slave (
    output start, halt, exec_done, ir_data,
    input  pc_increment, ar_write, ir_write, mem_read, bus_select,
           opcode_d, i_flag, exec_start, t_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode sequencer: T0..T2 (optional T3 indirect) then hand-off to EXEC.
// Define FETCH_SEQ_INDIRECT_EN to add the T3 indirect-address cycle.
module fetch_sequencer #(
  parameter int               WORD_W  = 16,
  parameter int               SEL_W   = 3,
  parameter logic [SEL_W-1:0] SEL_PC  = 3'd2,
  parameter logic [SEL_W-1:0] SEL_IR  = 3'd5,
  parameter logic [SEL_W-1:0] SEL_MEM = 3'd7
) (
  input  logic               clock,
  input  logic               clear,
  fetch_sequencer_if.master  bus
);

`ifdef FETCH_SEQ_INDIRECT_EN
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, EXEC} state_t;
`else
  typedef enum logic [2:0] {IDLE, T0, T1, T2, EXEC} state_t;
`endif

  state_t            state;
  logic              pc_increment;
  logic              ar_write;
  logic              ir_write;
  logic              mem_read;
  logic [SEL_W-1:0]  bus_select;
  logic [7:0]        opcode_d;
  logic              i_flag;
  logic              exec_start;
  logic [3:0]        t_count;

  logic [2:0]        ir_opcode;
  logic              ir_ibit;
  logic              unused_ir_addr;

  assign ir_opcode      = bus.ir_data[WORD_W-2:WORD_W-4];
  assign ir_ibit        = bus.ir_data[WORD_W-1];
  assign unused_ir_addr = ^bus.ir_data[WORD_W-5:0];

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    onehot8 = 8'd1 << code;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    sat_inc4 = (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  // Outputs are registered for the state being entered, so they track the state register exactly.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state        <= IDLE;
      pc_increment <= 1'b0;
      ar_write     <= 1'b0;
      ir_write     <= 1'b0;
      mem_read     <= 1'b0;
      bus_select   <= '0;
      opcode_d     <= 8'h00;
      i_flag       <= 1'b0;
      exec_start   <= 1'b0;
      t_count      <= 4'd0;
    end else begin
      pc_increment <= 1'b0;
      ar_write     <= 1'b0;
      ir_write     <= 1'b0;
      mem_read     <= 1'b0;
      bus_select   <= '0;
      exec_start   <= 1'b0;
      case (state)
        IDLE: begin
          t_count <= 4'd0;
          if (bus.start && !bus.halt) begin
            state      <= T0;
            ar_write   <= 1'b1;
            bus_select <= SEL_PC;
          end
        end
        T0: begin
          state        <= T1;
          mem_read     <= 1'b1;
          bus_select   <= SEL_MEM;
          ir_write     <= 1'b1;
          pc_increment <= 1'b1;
          t_count      <= 4'd1;
        end
        T1: begin
          state      <= T2;
          bus_select <= SEL_IR;
          ar_write   <= 1'b1;
          t_count    <= 4'd2;
        end
        T2: begin
          opcode_d <= onehot8(ir_opcode);
          i_flag   <= ir_ibit;
          t_count  <= 4'd3;
`ifdef FETCH_SEQ_INDIRECT_EN
          // Memory-reference instruction with I=1: fetch the effective address first.
          if (ir_opcode != 3'd7 && ir_ibit) begin
            state      <= T3;
            mem_read   <= 1'b1;
            bus_select <= SEL_MEM;
            ar_write   <= 1'b1;
          end else begin
            state      <= EXEC;
            exec_start <= 1'b1;
          end
`else
          state      <= EXEC;
          exec_start <= 1'b1;
`endif
        end
`ifdef FETCH_SEQ_INDIRECT_EN
        T3: begin
          state      <= EXEC;
          exec_start <= 1'b1;
          t_count    <= 4'd4;
        end
`endif
        EXEC: begin
          if (bus.exec_done) begin
            t_count <= 4'd0;
            if (bus.halt) begin
              state <= IDLE;
            end else begin
              state      <= T0;
              ar_write   <= 1'b1;
              bus_select <= SEL_PC;
            end
          end else begin
            t_count <= sat_inc4(t_count);
          end
        end
        default: begin
          state   <= IDLE;
          t_count <= 4'd0;
        end
      endcase
    end
  end

  assign bus.pc_increment = pc_increment;
  assign bus.ar_write     = ar_write;
  assign bus.ir_write     = ir_write;
  assign bus.mem_read     = mem_read;
  assign bus.bus_select   = bus_select;
  assign bus.opcode_d     = opcode_d;
  assign bus.i_flag       = i_flag;
  assign bus.exec_start   = exec_start;
  assign bus.t_count      = t_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer; expectations follow FETCH_SEQ_INDIRECT_EN when defined.
module tb_fetch_sequencer;

  localparam int S_IDLE = 0;
  localparam int S_T0   = 1;
  localparam int S_T1   = 2;
  localparam int S_T2   = 3;
  localparam int S_T3   = 4;
  localparam int S_EXEC = 5;

  logic clock;
  logic clear;
  int   vectors;
  int   miscompares;
  logic [20:0] sb_q[$];

  fetch_sequencer_if #(.WORD_W(16), .SEL_W(3)) bus ();

  fetch_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not produced");
    $fatal(1, "watchdog expired");
  end

  // Expected output bundle for a given control state and held decode values.
  function automatic logic [20:0] ev(input int st, input int t, input logic [7:0] od,
                                     input logic ifl, input logic es);
    logic pc, ar, ir, mr;
    logic [2:0] sel;
    pc = 1'b0; ar = 1'b0; ir = 1'b0; mr = 1'b0; sel = 3'd0;
    case (st)
      S_T0: begin ar = 1'b1; sel = 3'd2; end
      S_T1: begin mr = 1'b1; sel = 3'd7; ir = 1'b1; pc = 1'b1; end
      S_T2: begin ar = 1'b1; sel = 3'd5; end
      S_T3: begin mr = 1'b1; sel = 3'd7; ar = 1'b1; end
      default: ;
    endcase
    ev = {pc, ar, ir, mr, sel, od, ifl, es, 4'(t)};
  endfunction

  function automatic logic [20:0] observed();
    observed = {bus.pc_increment, bus.ar_write, bus.ir_write, bus.mem_read, bus.bus_select,
                bus.opcode_d, bus.i_flag, bus.exec_start, bus.t_count};
  endfunction

  task automatic check_now(input string tag);
    logic [20:0] exp_v;
    logic [20:0] obs_v;
    exp_v = sb_q.pop_front();
    obs_v = observed();
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
    end
  endtask

  task automatic cycle(input string tag, input logic [20:0] exp_v);
    sb_q.push_back(exp_v);
    @(posedge clock);
    #1;
    check_now(tag);
  endtask

  int base;
  int te;

  initial begin
    vectors = 0;
    miscompares = 0;
    clear = 1'b1;
    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.exec_done = 1'b0;
    bus.ir_data = 16'h0000;
    #1;
    sb_q.push_back(ev(S_IDLE, 0, 8'h00, 1'b0, 1'b0));
    check_now("reset");
    @(posedge clock); @(posedge clock); #1;
    clear = 1'b0;
    cycle("idle_after_reset", ev(S_IDLE, 0, 8'h00, 1'b0, 1'b0));

    // Basic fetch of 16'h2005: D2, direct.
    bus.ir_data = 16'h2005;
    bus.start = 1'b1;
    cycle("f1_t0", ev(S_T0, 0, 8'h00, 1'b0, 1'b0));
    bus.start = 1'b0;
    cycle("f1_t1", ev(S_T1, 1, 8'h00, 1'b0, 1'b0));
    cycle("f1_t2", ev(S_T2, 2, 8'h00, 1'b0, 1'b0));
    cycle("f1_exec1", ev(S_EXEC, 3, 8'h04, 1'b0, 1'b1));
    cycle("f1_exec2", ev(S_EXEC, 4, 8'h04, 1'b0, 1'b0));

    // exec_done without halt refetches; exec_done during T0..T2 is ignored.
    bus.exec_done = 1'b1;
    cycle("done_to_t0", ev(S_T0, 0, 8'h04, 1'b0, 1'b0));
    cycle("ign_done_t1", ev(S_T1, 1, 8'h04, 1'b0, 1'b0));
    bus.halt = 1'b1;
    cycle("ign_done_t2", ev(S_T2, 2, 8'h04, 1'b0, 1'b0));
    bus.exec_done = 1'b0;
    bus.halt = 1'b0;
    cycle("f2_exec1", ev(S_EXEC, 3, 8'h04, 1'b0, 1'b1));
    bus.exec_done = 1'b1;
    bus.halt = 1'b1;
    cycle("halt_to_idle", ev(S_IDLE, 0, 8'h04, 1'b0, 1'b0));
    bus.exec_done = 1'b0;
    bus.start = 1'b1;
    cycle("start_and_halt", ev(S_IDLE, 0, 8'h04, 1'b0, 1'b0));
    bus.halt = 1'b0;

    // 16'h8123: D0 with I=1, indirect cycle only when enabled.
    bus.ir_data = 16'h8123;
    cycle("f3_t0", ev(S_T0, 0, 8'h04, 1'b0, 1'b0));
    bus.start = 1'b0;
    cycle("f3_t1", ev(S_T1, 1, 8'h04, 1'b0, 1'b0));
    cycle("f3_t2", ev(S_T2, 2, 8'h04, 1'b0, 1'b0));
`ifdef FETCH_SEQ_INDIRECT_EN
    cycle("f3_t3", ev(S_T3, 3, 8'h01, 1'b1, 1'b0));
    base = 4;
`else
    base = 3;
`endif
    cycle("f3_exec1", ev(S_EXEC, base, 8'h01, 1'b1, 1'b1));

    // Long execute without exec_done: t_count saturates.
    for (int k = 1; k <= 20; k++) begin
      te = base + k;
      if (te > 15) te = 15;
      cycle("sat_exec", ev(S_EXEC, te, 8'h01, 1'b1, 1'b0));
    end
    bus.exec_done = 1'b1;
    bus.halt = 1'b1;
    cycle("f3_halt", ev(S_IDLE, 0, 8'h01, 1'b1, 1'b0));
    bus.exec_done = 1'b0;
    bus.halt = 1'b0;

    // 16'hF800: D7 with I=1 never takes the indirect cycle.
    bus.ir_data = 16'hF800;
    bus.start = 1'b1;
    cycle("f4_t0", ev(S_T0, 0, 8'h01, 1'b1, 1'b0));
    bus.start = 1'b0;
    cycle("f4_t1", ev(S_T1, 1, 8'h01, 1'b1, 1'b0));
    cycle("f4_t2", ev(S_T2, 2, 8'h01, 1'b1, 1'b0));
    cycle("f4_exec1", ev(S_EXEC, 3, 8'h80, 1'b1, 1'b1));
    bus.exec_done = 1'b1;
    bus.halt = 1'b1;
    cycle("f4_halt", ev(S_IDLE, 0, 8'h80, 1'b1, 1'b0));
    bus.exec_done = 1'b0;
    bus.halt = 1'b0;

    // Asynchronous clear in the middle of T1.
    bus.ir_data = 16'h2005;
    bus.start = 1'b1;
    cycle("f5_t0", ev(S_T0, 0, 8'h80, 1'b1, 1'b0));
    bus.start = 1'b0;
    cycle("f5_t1", ev(S_T1, 1, 8'h80, 1'b1, 1'b0));
    #2;
    clear = 1'b1;
    #1;
    sb_q.push_back(ev(S_IDLE, 0, 8'h00, 1'b0, 1'b0));
    check_now("async_clear");
    @(posedge clock); #1;
    clear = 1'b0;
    cycle("post_clear_idle1", ev(S_IDLE, 0, 8'h00, 1'b0, 1'b0));
    cycle("post_clear_idle2", ev(S_IDLE, 0, 8'h00, 1'b0, 1'b0));
    bus.start = 1'b1;
    cycle("restart_t0", ev(S_T0, 0, 8'h00, 1'b0, 1'b0));
    bus.start = 1'b0;
    cycle("restart_t1", ev(S_T1, 1, 8'h00, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
